mem_bridge: RTL
===============

# mem_bridge

Memory-side bridge directly downstream of the CPU core. It accepts the core's single-word data reads and writes and its 32-bit instruction fetches, and sequences them onto a 16-bit request/acknowledge backend port. It returns read data, the assembled instruction word, and the `busy`/`ready` handshake the core's decoder and fetch stage stall on.

## Interface
Parameters:
- `ADDR_W`, 24: backend word-address width; fixed layout below requires 24.
- `INSTR_SPACE`, 7'h01: upper 7 address bits for instruction-space accesses.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ram_read`  in  1  CPU read request; held until `mem_ready`.
- `ram_write`  in  1  CPU write request; held until `mem_ready`.
- `ram_instr_access`  in  1  qualifies request as instruction space.
- `addr`  in  16  CPU word address.
- `wdata`  in  16  CPU write data.
- `mem_rdata`  out  16  last data-read result.
- `instr`  out  32  last fetched instruction.
- `mem_busy`  out  1  transaction in progress.
- `mem_ready`  out  1  one-cycle completion pulse.
- `m_req`  out  1  backend request; held until `m_ack`.
- `m_we`  out  1  backend write enable.
- `m_addr`  out  ADDR_W  backend word address.
- `m_wdata`  out  16  backend write data.
- `m_ack`  in  1  backend accepted request this cycle.
- `m_rvalid`  in  1  read data valid, at least 1 cycle after `m_ack`.
- `m_rdata`  in  16  backend read data.

## Operation
- Address map:
  - Data access: `m_addr = {8'h00, addr}`.
  - Instruction access: `m_addr = {INSTR_SPACE, addr, beat}`. Beat 0 goes to `instr[15:0]`; beat 1 goes to `instr[31:16]`.
- FSM states: IDLE, REQ, WAIT, DONE. A `beat` flag is added for instruction reads.
- IDLE:
  - If `ram_write` is high: capture addr/wdata/space, go to REQ with `m_we=1`.
  - Else if `ram_read` is high: capture, go to REQ with `m_we=0`, `beat=0`.
  - When both are high, the write wins and the read is dropped.
- REQ: hold `m_req`, `m_we`, `m_addr`, `m_wdata` stable until `m_ack`.
  - On ack of a write: go to DONE.
  - On ack of a read: go to WAIT.
- WAIT: on `m_rvalid`, latch `m_rdata`.
  - Data read: load `mem_rdata`, go to DONE.
  - Instruction read, beat 0: load `instr[15:0]`, set `beat=1`, go to REQ.
  - Instruction read, beat 1: load `instr[31:16]`, go to DONE.
- DONE: `mem_ready=1` for exactly this one cycle, then return to IDLE.
  - Requests present during DONE are ignored.
  - The core drops or changes its request after seeing `ready`.
- `m_rvalid` is ignored outside WAIT. `m_ack` is ignored outside REQ.
- `mem_rdata` and `instr` hold their value until overwritten by a completing read of their kind.
- Instruction-space writes are legal (program loading) and use the instruction address layout with beat = `addr` LSB unused (beat 0).

## Timing
- Reset values: state IDLE; `mem_busy`, `mem_ready`, `m_req`, `m_we` = 0; `m_addr`, `m_wdata`, `mem_rdata`, `instr` = 0; buffer invalid.
- Reset asserted mid-transaction aborts immediately to IDLE. A late `m_rvalid` after reset is discarded.
- All outputs are registered.
  - `mem_busy` = 1 from the cycle after IDLE accepts a request through the DONE cycle inclusive.
  - `mem_busy` = 0 in IDLE.
- Minimum latency (request seen at T0, `m_ack` at first REQ cycle, `m_rvalid` one cycle later):
  - Write: `m_req` at T0+1, ready at T0+2.
  - Data read: ready at T0+3.
  - Instruction fetch: ready at T0+5.
- Each backend stall cycle (no ack, no rvalid) adds one cycle. There is no timeout.

## Configuration
- `MEM_BRIDGE_FETCH_BUF_EN`: one-entry instruction buffer (tag = 16-bit addr, valid bit).
  - Defined:
    - An instruction read hitting a valid tag goes IDLE→DONE without touching the backend, with `busy` and `ready` on T0+1.
    - A completed fetch loads tag and valid.
    - Any instruction-space write invalidates the buffer.
  - Undefined: no buffer; every fetch performs both beats.

## Test plan
- Data write addr=16'h1234, wdata=16'hBEEF, ack at first REQ cycle -> `m_addr=24'h001234`, `m_we=1`, `m_wdata=16'hBEEF`; `mem_ready` pulses at T0+2, exactly one cycle.
- Data read addr=16'h0010, ack delayed 3 cycles, rvalid returns 16'hA5A5 -> `m_req` held 4 cycles with stable address; `mem_rdata=16'hA5A5`; ready at T0+6.
- Instruction fetch addr=16'h0008, beats return 16'h1111 then 16'h2222 -> `m_addr` 24'h020010 then 24'h020011; `instr=32'h2222_1111`.
- Read and write both high, addr=16'h0044 -> write only (`m_we=1`), a single ready pulse, `mem_rdata` unchanged.
- `rst` pulsed while in WAIT, followed by a stray `m_rvalid` with 16'hFFFF -> all outputs return to reset values, no ready, `mem_rdata` stays 0.
- With `MEM_BRIDGE_FETCH_BUF_EN`: fetch 16'h0008 twice -> second fetch issues no `m_req` and readies at T0+1. Then instruction write to 16'h0008 and refetch -> backend accessed again.

Source files
------------

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge
// Purpose  : Bridges CPU single-word data reads/writes and 32-bit instruction
//            fetches onto a 16-bit request/acknowledge backend port. Data
//            accesses map to {8'h00, addr}. Instruction accesses map to
//            {INSTR_SPACE, addr, beat}. A fetch takes two backend beats:
//            beat 0 is the low half and beat 1 is the high half.
// Ports    : clk, rst (async, active-high)
//            CPU side     : ram_read, ram_write, ram_instr_access, addr, wdata
//                           -> mem_rdata, instr, mem_busy, mem_ready
//            Backend side : m_req, m_we, m_addr, m_wdata
//                           <- m_ack, m_rvalid, m_rdata
// Options  : MEM_BRIDGE_FETCH_BUF_EN - one-entry instruction buffer.
//            It holds a tag (16-bit addr) and a valid bit. A hit completes
//            the fetch without any backend access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bridge #(
    parameter int         ADDR_W      = 24,
    parameter logic [6:0] INSTR_SPACE = 7'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_read,
    input  logic              ram_write,
    input  logic              ram_instr_access,
    input  logic [15:0]       addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       mem_rdata,
    output logic [31:0]       instr,
    output logic              mem_busy,
    output logic              mem_ready,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [15:0]       m_wdata,
    input  logic              m_ack,
    input  logic              m_rvalid,
    input  logic [15:0]       m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                beat_q, beat_d;       // instruction beat in flight
    logic                wr_q, wr_d;           // current transaction is a write
    logic                ispace_q, ispace_d;   // current transaction is instruction space
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                m_req_q, m_req_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [15:0]         m_wdata_q, m_wdata_d;
    logic [15:0]         rdata_q, rdata_d;
    logic [31:0]         instr_q, instr_d;
`ifdef MEM_BRIDGE_FETCH_BUF_EN
    logic [15:0]         tag_q, tag_d;
    logic                valid_q, valid_d;
`endif

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wr_d      = wr_q;
        ispace_d  = ispace_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        rdata_d   = rdata_q;
        instr_d   = instr_q;
`ifdef MEM_BRIDGE_FETCH_BUF_EN
        tag_d     = tag_q;
        valid_d   = valid_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d  = 1'b0;
                m_req_d = 1'b0;
                m_we_d  = 1'b0;
                // A write takes priority; a simultaneous read is dropped.
                if (ram_write) begin
                    wr_d      = 1'b1;
                    ispace_d  = ram_instr_access;
                    beat_d    = 1'b0;
                    m_wdata_d = wdata;
                    m_addr_d  = ram_instr_access ? {INSTR_SPACE, addr, 1'b0}
                                                 : {8'h00, addr};
                    state_d   = S_REQ;
                    busy_d    = 1'b1;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b1;
`ifdef MEM_BRIDGE_FETCH_BUF_EN
                    // Program loading may overwrite the buffered word.
                    if (ram_instr_access) begin
                        valid_d = 1'b0;
                    end
`endif
                end else if (ram_read) begin
                    wr_d     = 1'b0;
                    ispace_d = ram_instr_access;
                    beat_d   = 1'b0;
                    busy_d   = 1'b1;
`ifdef MEM_BRIDGE_FETCH_BUF_EN
                    // A hit needs no backend access. instr already holds the
                    // word, because the last completed fetch loaded the tag.
                    if (ram_instr_access && valid_q && (tag_q == addr)) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                    end else begin
                        m_addr_d = ram_instr_access ? {INSTR_SPACE, addr, 1'b0}
                                                    : {8'h00, addr};
                        state_d  = S_REQ;
                        m_req_d  = 1'b1;
                    end
`else
                    m_addr_d = ram_instr_access ? {INSTR_SPACE, addr, 1'b0}
                                                : {8'h00, addr};
                    state_d  = S_REQ;
                    m_req_d  = 1'b1;
`endif
                end
            end
            S_REQ: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    if (wr_q) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (m_rvalid) begin
                    if (!ispace_q) begin
                        rdata_d = m_rdata;
                        state_d = S_DONE;
                        ready_d = 1'b1;
                    end else if (!beat_q) begin
                        // Low half is in; request the high half at addr LSB=1.
                        instr_d[15:0] = m_rdata;
                        beat_d        = 1'b1;
                        m_addr_d[0]   = 1'b1;
                        m_req_d       = 1'b1;
                        state_d       = S_REQ;
                    end else begin
                        instr_d[31:16] = m_rdata;
                        state_d        = S_DONE;
                        ready_d        = 1'b1;
`ifdef MEM_BRIDGE_FETCH_BUF_EN
                        tag_d          = m_addr_q[16:1];
                        valid_d        = 1'b1;
`endif
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            beat_q    <= 1'b0;
            wr_q      <= 1'b0;
            ispace_q  <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= 16'h0000;
            rdata_q   <= 16'h0000;
            instr_q   <= 32'h0000_0000;
`ifdef MEM_BRIDGE_FETCH_BUF_EN
            tag_q     <= 16'h0000;
            valid_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wr_q      <= wr_d;
            ispace_q  <= ispace_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            rdata_q   <= rdata_d;
            instr_q   <= instr_d;
`ifdef MEM_BRIDGE_FETCH_BUF_EN
            tag_q     <= tag_d;
            valid_q   <= valid_d;
`endif
        end
    end

    assign mem_rdata = rdata_q;
    assign instr     = instr_q;
    assign mem_busy  = busy_q;
    assign mem_ready = ready_q;
    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;

endmodule

`default_nettype wire
